// File: rtl/icache_responder.sv
// icache_responder
//   Direct-mapped, one-word-per-line, read-only instruction cache that answers
//   the datapath's fetch port and refills misses from the memory arbiter.
//
//   Optional feature macro: ICACHE_PERF_EN (adds saturating hit/miss counters).
//
// Ports:
//   CLK        clock, all state updates on the rising edge
//   RST        synchronous active-high reset
//   imemREN    datapath fetch request
//   imemaddr   fetch byte address (bits [1:0] ignored)
//   ihit       fetched word valid this cycle
//   imemload   fetched instruction, 0 when ihit=0
//   flush      invalidate all lines
//   iREN       memory read request (only in FETCH)
//   iaddr      word-aligned memory read address, 0 when iREN=0
//   iwait      memory busy; iwait=0 with iREN=1 means iload is valid
//   iload      memory read data
//   hit_count  (ICACHE_PERF_EN) IDLE cycles that hit, saturating
//   miss_count (ICACHE_PERF_EN) IDLE->FETCH transitions, saturating
//
// Handshake: a memory read is outstanding for exactly the cycles iREN=1;
// iaddr is held stable for the whole transaction and it completes on the
// first cycle with iREN=1 and iwait=0.
module icache_responder #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        flush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t              state_q, state_d;
    logic [31:0]         miss_addr_q;
    logic                flush_pend_q;
    logic [SETS-1:0]     valid_q;
    logic [TAG_W-1:0]    tag_q  [SETS];
    logic [31:0]         data_q [SETS];

    logic [IDX_W-1:0]    req_idx, miss_idx;
    logic [TAG_W-1:0]    req_tag, miss_tag;
    logic                lookup_hit;
    logic                miss_start;
    logic                fill_done;
    logic                flush_eff;
    logic                fill_we;
    logic                unused_addr_bits;

    assign req_idx  = imemaddr[IDX_W+1:2];
    assign req_tag  = imemaddr[31:IDX_W+2];
    assign miss_idx = miss_addr_q[IDX_W+1:2];
    assign miss_tag = miss_addr_q[31:IDX_W+2];
    assign unused_addr_bits = ^imemaddr[1:0];

    assign lookup_hit = imemREN & valid_q[req_idx] & (tag_q[req_idx] == req_tag) & ~flush;
    assign miss_start = (state_q == IDLE) & imemREN & ~lookup_hit & ~flush;
    assign fill_done  = (state_q == FETCH) & ~iwait;
    // A flush seen on any FETCH cycle, including the completion cycle itself,
    // cancels the fill and the forward.
    assign flush_eff  = flush_pend_q | flush;
    assign fill_we    = fill_done & ~flush_eff;

    always_comb begin
        state_d  = state_q;
        ihit     = 1'b0;
        imemload = 32'd0;
        iREN     = 1'b0;
        iaddr    = 32'd0;
        case (state_q)
            IDLE: begin
                if (lookup_hit) begin
                    ihit     = 1'b1;
                    imemload = data_q[req_idx];
                end else if (miss_start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = miss_addr_q;
                if (fill_done) begin
                    state_d = IDLE;
                    // Forward only if the datapath still wants this word.
                    if (!flush_eff && imemREN && (imemaddr[31:2] == miss_addr_q[31:2])) begin
                        ihit     = 1'b1;
                        imemload = iload;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            miss_addr_q  <= 32'd0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    flush_pend_q <= 1'b0;
                    if (flush) begin
                        valid_q <= '0;
                    end else if (miss_start) begin
                        miss_addr_q <= {imemaddr[31:2], 2'b00};
                    end
                end
                FETCH: begin
                    if (fill_done) begin
                        flush_pend_q <= 1'b0;
                        if (flush_eff) begin
                            valid_q <= '0;
                        end else begin
                            valid_q[miss_idx] <= 1'b1;
                        end
                    end else if (flush) begin
                        flush_pend_q <= 1'b1;
                    end
                end
                default: flush_pend_q <= 1'b0;
            endcase
        end
    end

    // Tag/data arrays need no reset: a line is only read when its valid bit is set.
    always_ff @(posedge CLK) begin
        if (fill_we) begin
            tag_q[miss_idx]  <= miss_tag;
            data_q[miss_idx] <= iload;
        end
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else begin
            if (lookup_hit && (state_q == IDLE) && (hit_count != 32'hFFFF_FFFF)) begin
                hit_count <= hit_count + 32'd1;
            end
            if (miss_start && (miss_count != 32'hFFFF_FFFF)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_responder.sv
module tb_icache_responder;

    localparam int SETS = 16;

    logic        CLK;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        flush;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int tests = 0;
    int fails = 0;

    // Reference cache: which word address each line holds, and its data.
    bit          m_valid [SETS];
    logic [29:0] m_word  [SETS];
    logic [31:0] m_data  [SETS];

    icache_responder #(.SETS(SETS)) dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .flush(flush), .iREN(iREN),
        .iaddr(iaddr), .iwait(iwait), .iload(iload)
`ifdef ICACHE_PERF_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int midx(input logic [31:0] a);
        return int'((a >> 2) % 32'(SETS));
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        int ix;
        ix = midx(a);
        return m_valid[ix] && (m_word[ix] == a[31:2]);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ({2'b00, a[31:2]} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_quiet(input string tag);
        chk({tag, "_ihit"}, {31'd0, ihit}, 32'd0);
        chk({tag, "_load"}, imemload, 32'd0);
        chk({tag, "_iren"}, {31'd0, iREN}, 32'd0);
        chk({tag, "_iaddr"}, iaddr, 32'd0);
    endtask

    // One fetch of address a: hit from the model, or a miss served by the
    // bench's memory after lat busy cycles returning d.
    task automatic fetch_req(input logic [31:0] a, input int lat, input logic [31:0] d);
        int ix;
        logic [31:0] al;
        ix = midx(a);
        al = {a[31:2], 2'b00};
        imemREN = 1'b1; imemaddr = a; flush = 1'b0; iwait = 1'b1; iload = 32'd0;
        #2;
        if (m_hit(a)) begin
            chk("hit_ihit", {31'd0, ihit}, 32'd1);
            chk("hit_data", imemload, m_data[ix]);
            chk("hit_iren", {31'd0, iREN}, 32'd0);
            tick();
        end else begin
            chk("miss_ihit", {31'd0, ihit}, 32'd0);
            chk("miss_load", imemload, 32'd0);
            chk("miss_iren", {31'd0, iREN}, 32'd0);
            tick();
            for (int k = 0; k < lat; k++) begin
                #2;
                chk("wait_iren", {31'd0, iREN}, 32'd1);
                chk("wait_iaddr", iaddr, al);
                chk("wait_ihit", {31'd0, ihit}, 32'd0);
                tick();
            end
            iwait = 1'b0; iload = d;
            #2;
            chk("done_iren", {31'd0, iREN}, 32'd1);
            chk("done_iaddr", iaddr, al);
            chk("done_ihit", {31'd0, ihit}, 32'd1);
            chk("done_load", imemload, d);
            tick();
            iwait = 1'b1; iload = 32'd0;
            m_valid[ix] = 1'b1;
            m_word[ix]  = a[31:2];
            m_data[ix]  = d;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1; imemREN = 1'b0; imemaddr = 32'd0; flush = 1'b0; iwait = 1'b1; iload = 32'd0;
        tick();
        tick();
        RST = 1'b0;
        m_clear();
    endtask

    initial begin
        logic [31:0] a;
        int r;

        // Reset state
        do_reset();
        #2;
        chk_idle_quiet("reset");
        tick();

        // Cold miss, 3 busy cycles, then a direct hit
        fetch_req(32'h0000_0040, 3, 32'h8C22_0004);
        fetch_req(32'h0000_0040, 0, 32'd0);

        // Conflict on index 1
        fetch_req(32'h0000_0004, 1, 32'h1111_0004);
        fetch_req(32'h0000_0004, 0, 32'd0);
        fetch_req(32'h0000_0044, 0, 32'h2222_0044);
        fetch_req(32'h0000_0004, 2, 32'h3333_0004);
        fetch_req(32'h0000_0040, 0, 32'd0);

        // Redirect mid-miss: 0x100 fills but is not forwarded
        imemREN = 1'b1; imemaddr = 32'h0000_0100; iwait = 1'b1;
        #2;
        chk("redir_miss_ihit", {31'd0, ihit}, 32'd0);
        tick();
        #2;
        chk("redir_iaddr0", iaddr, 32'h0000_0100);
        tick();
        imemaddr = 32'h0000_0200;
        #2;
        chk("redir_iaddr1", iaddr, 32'h0000_0100);
        chk("redir_ihit1", {31'd0, ihit}, 32'd0);
        tick();
        iwait = 1'b0; iload = 32'hAAAA_0100;
        #2;
        chk("redir_done_iren", {31'd0, iREN}, 32'd1);
        chk("redir_done_ihit", {31'd0, ihit}, 32'd0);
        chk("redir_done_load", imemload, 32'd0);
        tick();
        iwait = 1'b1; iload = 32'd0;
        m_valid[0] = 1'b1; m_word[0] = 30'h40; m_data[0] = 32'hAAAA_0100;
        fetch_req(32'h0000_0100, 0, 32'd0);
        fetch_req(32'h0000_0200, 1, 32'hBBBB_0200);

        // Flush in IDLE
        fetch_req(32'h0000_0010, 0, 32'hCCCC_0010);
        fetch_req(32'h0000_0020, 1, 32'hDDDD_0020);
        imemREN = 1'b1; imemaddr = 32'h0000_0010; flush = 1'b1;
        #2;
        chk("flush_ihit", {31'd0, ihit}, 32'd0);
        chk("flush_iren", {31'd0, iREN}, 32'd0);
        tick();
        flush = 1'b0;
        m_clear();
        fetch_req(32'h0000_0010, 0, 32'hCCCC_0010);
        fetch_req(32'h0000_0020, 0, 32'hDDDD_0020);

        // Flush mid-FETCH: no forward, no fill, everything invalid
        imemREN = 1'b1; imemaddr = 32'h0000_0030; iwait = 1'b1;
        tick();
        flush = 1'b1;
        #2;
        chk("fflush_iren", {31'd0, iREN}, 32'd1);
        tick();
        flush = 1'b0; iwait = 1'b0; iload = 32'hEEEE_0030;
        #2;
        chk("fflush_done_ihit", {31'd0, ihit}, 32'd0);
        chk("fflush_done_load", imemload, 32'd0);
        tick();
        iwait = 1'b1; iload = 32'd0;
        m_clear();
        fetch_req(32'h0000_0030, 0, 32'hEEEE_0030);
        fetch_req(32'h0000_0010, 0, 32'hCCCC_0010);

        // Reset mid-FETCH
        fetch_req(32'h0000_0050, 0, 32'h5555_0050);
        imemREN = 1'b1; imemaddr = 32'h0000_0060; iwait = 1'b1;
        tick();
        #2;
        chk("rfetch_iren", {31'd0, iREN}, 32'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0; imemREN = 1'b0;
        #2;
        chk_idle_quiet("rfetch");
        tick();
        m_clear();
        fetch_req(32'h0000_0050, 0, 32'h5555_0050);

        // Randomized traffic against the reference model
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) |
                32'($urandom_range(0, 3));
            if (r == 0) begin
                imemREN = 1'b0; imemaddr = a; flush = 1'b0;
                #2;
                chk_idle_quiet("rnd_idle");
                tick();
            end else if (r == 1) begin
                imemREN = 1'b1; imemaddr = a; flush = 1'b1;
                #2;
                chk("rnd_flush_ihit", {31'd0, ihit}, 32'd0);
                chk("rnd_flush_iren", {31'd0, iREN}, 32'd0);
                tick();
                flush = 1'b0;
                m_clear();
            end else begin
                fetch_req(a, $urandom_range(0, 3), mem_word(a));
            end
        end

`ifdef ICACHE_PERF_EN
        do_reset();
        #2;
        chk("perf_hit0", hit_count, 32'd0);
        chk("perf_miss0", miss_count, 32'd0);
        tick();
        fetch_req(32'h0000_0040, 1, 32'h8C22_0004);
        for (int i = 0; i < 5; i++) fetch_req(32'h0000_0040, 0, 32'd0);
        imemREN = 1'b0;
        #2;
        chk("perf_hit", hit_count, 32'd5);
        chk("perf_miss", miss_count, 32'd1);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Responder side of the datapath's instruction-fetch handshake.
- Answers imemREN/imemaddr with ihit/imemload from a direct-mapped, one-word-per-line instruction cache.
- On a miss, issues a single-word read to the memory controller over an iREN/iaddr/iwait/iload handshake, fills the line and forwards the word.
- Sits between the datapath's instruction port and the memory arbiter.

Parameters:
- SETS, 16, number of cache lines; power of two, 2 to 256.
- IDX_W, $clog2(SETS), index width; derived, not overridden.

Ports:
- CLK  input  1  clock, all state updates on rising edge
- RST  input  1  reset, synchronous, active-high
- imemREN  input  1  datapath fetch request
- imemaddr  input  32  fetch byte address; bits [1:0] ignored
- ihit  output  1  fetched word valid this cycle
- imemload  output  32  fetched instruction; 0 when ihit=0
- flush  input  1  invalidate all lines
- iREN  output  1  memory read request
- iaddr  output  32  memory read address, word aligned
- iwait  input  1  memory busy; iwait=0 while iREN=1 means iload valid this cycle
- iload  input  32  memory read data

Behaviour:
- Reset and clock: one clock CLK. Reset RST is synchronous, active-high.
- Address split:
  - index = imemaddr[IDX_W+1:2]
  - tag = imemaddr[31:IDX_W+2]
  - Storage per line: valid bit, tag, 32-bit data.
- Reset (RST=1 at an edge):
  - All valid bits cleared; state goes to IDLE; miss_addr = 0.
  - ihit=0, imemload=0, iREN=0, iaddr=0 from the following cycle.
  - Takes priority over everything else, including mid-FETCH. The memory request is abandoned and iREN is low in the next cycle.
- FSM states: IDLE, FETCH.
- IDLE:
  - ihit is combinational: ihit = imemREN & valid[index] & tag match & !flush. imemload = data[index] when ihit=1, else 0.
  - Miss (imemREN=1, no hit, flush=0): latch miss_addr = {imemaddr[31:2],2'b00}, go to FETCH.
  - imemREN=0: no action; ihit=0.
  - flush=1: all valid bits cleared at the edge; ihit=0 this cycle; no miss started.
- FETCH:
  - iREN=1, iaddr=miss_addr, held stable until completion. ihit=0 except on the forwarded completion cycle.
  - Completion on the cycle iREN=1 and iwait=0:
    - Write data=iload, tag and valid to line index(miss_addr).
    - Forward: ihit=1 and imemload=iload in that same cycle, if imemREN=1 and imemaddr[31:2]==miss_addr[31:2].
    - Next state IDLE.
  - imemaddr changes during FETCH (branch redirect): the transaction still completes and the line is still filled. There is no forward; IDLE then re-evaluates the new address next cycle.
  - flush during FETCH: flush is sticky until completion. The transaction completes, the fill write is suppressed, there is no forward, and all valid bits are cleared. Return to IDLE.
- Latency:
  - Hit: 0 cycles (same-cycle ihit).
  - Miss: 1 cycle to enter FETCH, plus the memory latency; the word is forwarded on the completion cycle.
  - Minimum miss with iwait=0 immediately: ihit on the 2nd cycle of the request.
- Conflict: a fill to index i overwrites the previous line at i unconditionally (direct-mapped, no write-back; the cache is read-only).
- iREN is never asserted in IDLE. iaddr is 0 whenever iREN=0.

Optional Feature:
- Macro: ICACHE_PERF_EN.
- Defined:
  - Adds outputs hit_count (32) and miss_count (32), both reset to 0 by RST.
  - hit_count increments on every IDLE cycle with ihit=1. miss_count increments on each IDLE->FETCH transition.
  - Both saturate at 32'hFFFFFFFF. flush does not clear them.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Cold miss: RST, then imemREN=1, imemaddr=0x00000040, memory returns 0x8C220004 after 3 iwait cycles.
  - Required: iREN=1 with iaddr=0x00000040 from cycle 2; ihit=1 and imemload=0x8C220004 on the completion cycle.
  - The next cycle hits directly from IDLE.
- Hit and conflict (SETS=16): fill 0x00000004, then request 0x00000044 (same index 1, different tag).
  - Required: miss and iREN=1 with iaddr=0x00000044.
  - After fill, 0x00000004 misses again.
- Redirect mid-miss: miss on 0x100; while in FETCH, change imemaddr to 0x200 before memory completes.
  - Required: no ihit on completion; then FETCH for 0x200.
  - A later 0x100 request hits.
- Flush: fill 0x10 and 0x20, pulse flush for one cycle.
  - Required: ihit=0 during the flush cycle; both addresses miss afterward.
  - flush asserted mid-FETCH: no forward; the line remains invalid.
- Reset mid-FETCH: assert RST while iREN=1.
  - Required: iREN=0, iaddr=0, ihit=0 the next cycle; all lines invalid.
- ICACHE_PERF_EN: 1 miss then 5 hit cycles on 0x40.
  - Required: miss_count=1, hit_count=5. The forwarded completion cycle is not counted as a hit.
